// File: rtl/lfsr_gen.sv
// -----------------------------------------------------------------------------
// lfsr_gen
//
// Parametrised Fibonacci LFSR pseudo-random word source with a valid/ready
// output stream. The state register is the output word. A word is offered
// while en is high, and the LFSR advances one step each time that word is
// accepted. A runtime seed can be loaded; a zero seed is replaced by SEED
// so the register never locks up. A one-cycle wrap pulse marks the return
// to the sequence start value.
//
// Parameters
//   WIDTH  state/output width, 3..32
//   TAPS   feedback mask, bit i set means state[i] feeds the XOR
//   SEED   non-zero reset and lockup-recovery value
//
// Ports
//   clk         in   1      clock, rising edge
//   rst         in   1      asynchronous active-high reset
//   en          in   1      run enable; low withdraws/withholds the word
//   load        in   1      load load_value into state and start this cycle
//   load_value  in   WIDTH  seed to load (zero is replaced by SEED)
//   out_ready   in   1      consumer accepts lfsr_out this cycle
//   out_valid   out  1      lfsr_out holds a word to be consumed
//   lfsr_out    out  WIDTH  current LFSR state
//   wrap        out  1      pulse: state has returned to the start value
//   lockup      out  1      pulse: a zero seed was replaced by SEED
// -----------------------------------------------------------------------------
module lfsr_gen #(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(8'hB8),
    parameter logic [WIDTH-1:0] SEED  = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] lfsr_out,
    output logic             wrap,
    output logic             lockup
);

    // Parameter sanity checks, evaluated at elaboration.
    if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
        $error("lfsr_gen: WIDTH must be in the range 3..32");
    end
    if (SEED == '0) begin : g_bad_seed
        $error("lfsr_gen: SEED must be non-zero");
    end

    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] start_q, start_d;
    logic             valid_q, valid_d;
    logic             wrap_q, wrap_d;
    logic             lockup_q, lockup_d;

    logic             fb;
    logic [WIDTH-1:0] step_val;
    logic             accept;
    logic             load_zero;
    logic [WIDTH-1:0] load_seed;

    // Fibonacci feedback: parity of the tapped bits shifts in at bit 0.
    assign fb        = ^(state_q & TAPS);
    assign step_val  = {state_q[WIDTH-2:0], fb};
    assign accept    = valid_q & out_ready;

    // A zero seed would freeze the register at zero forever.
    assign load_zero = (load_value == '0);
    assign load_seed = load_zero ? SEED : load_value;

    always_comb begin
        // NOTE: every next-state signal gets a default before any branch, so
        // no path leaves one unassigned and no latch is inferred.
        state_d  = state_q;
        start_d  = start_q;
        valid_d  = en;
        wrap_d   = 1'b0;
        lockup_d = 1'b0;

        if (load) begin
            // Load wins over a same-cycle accept: the word is consumed but
            // no advance is applied, and the new seed is offered next.
            state_d  = load_seed;
            start_d  = load_seed;
            valid_d  = 1'b0;
            lockup_d = load_zero;
        end else if (accept) begin
            state_d = step_val;
            wrap_d  = (step_val == start_q);
        end
        // Without an accept the state holds, so a stalled word is stable;
        // dropping en simply withdraws it at the next edge.
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= SEED;
            start_q  <= SEED;
            valid_q  <= 1'b0;
            wrap_q   <= 1'b0;
            lockup_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            start_q  <= start_d;
            valid_q  <= valid_d;
            wrap_q   <= wrap_d;
            lockup_q <= lockup_d;
        end
    end

    assign lfsr_out  = state_q;
    assign out_valid = valid_q;
    assign wrap      = wrap_q;
    assign lockup    = lockup_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// -----------------------------------------------------------------------------
// tb_lfsr_gen
//
// Directed and randomized bench for lfsr_gen with its default parameters
// (WIDTH=8, TAPS=8'hB8, SEED=8'hFF). A transaction-level reference model
// tracks the offered word, sequence start and pulses; the LFSR step is
// computed arithmetically (parity of tapped bits, shift by doubling).
// -----------------------------------------------------------------------------
module tb_lfsr_gen;

    localparam int unsigned W    = 8;
    localparam logic [7:0]  TAPS = 8'hB8;
    localparam logic [7:0]  SEED = 8'hFF;

    logic         clk;
    logic         rst;
    logic         en;
    logic         load;
    logic [W-1:0] load_value;
    logic         out_ready;
    logic         out_valid;
    logic [W-1:0] lfsr_out;
    logic         wrap;
    logic         lockup;

    lfsr_gen #(
        .WIDTH (W),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load       (load),
        .load_value (load_value),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .lfsr_out   (lfsr_out),
        .wrap       (wrap),
        .lockup     (lockup)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int wrap_cnt = 0;

    // Reference model state.
    logic [7:0] m_word;
    logic [7:0] m_start;
    logic       m_valid;
    logic       m_wrap;
    logic       m_lockup;

    // Words observed being accepted (valid & ready before an edge).
    logic [7:0] acc_q[$];

    function automatic logic [7:0] ref_next(input logic [7:0] s);
        int unsigned par;
        int unsigned v;
        par = $countones(s & TAPS) % 2;
        v   = (int'(s) * 2 + par) % 256;
        return v[7:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_word   = SEED;
        m_start  = SEED;
        m_valid  = 1'b0;
        m_wrap   = 1'b0;
        m_lockup = 1'b0;
    endtask

    // Assert rst between clock edges and check the outputs respond at once.
    task automatic async_reset();
        @(negedge clk);
        #2;
        rst        = 1'b1;
        en         = 1'b0;
        load       = 1'b0;
        load_value = '0;
        out_ready  = 1'b0;
        #1;
        check("rst_lfsr_out", 32'(lfsr_out), 32'(SEED));
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_wrap", 32'(wrap), 32'd0);
        check("rst_lockup", 32'(lockup), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One clock cycle: drive inputs, advance the model, compare after the edge.
    task automatic cycle(input logic e, input logic l, input logic [7:0] lv, input logic r);
        logic       acc;
        logic [7:0] v;
        logic [7:0] nx;
        @(negedge clk);
        en         = e;
        load       = l;
        load_value = lv;
        out_ready  = r;
        #1;
        if (out_valid && out_ready) acc_q.push_back(lfsr_out);
        acc = m_valid && r;
        if (l) begin
            v        = (lv == 8'h00) ? SEED : lv;
            m_word   = v;
            m_start  = v;
            m_valid  = 1'b0;
            m_lockup = (lv == 8'h00);
            m_wrap   = 1'b0;
        end else begin
            m_lockup = 1'b0;
            m_wrap   = 1'b0;
            if (acc) begin
                nx     = ref_next(m_word);
                m_wrap = (nx == m_start);
                m_word = nx;
            end
            m_valid = e;
        end
        @(posedge clk);
        #1;
        if (wrap) wrap_cnt++;
        check("model_lfsr_out", 32'(lfsr_out), 32'(m_word));
        check("model_out_valid", 32'(out_valid), 32'(m_valid));
        check("model_wrap", 32'(wrap), 32'(m_wrap));
        check("model_lockup", 32'(lockup), 32'(m_lockup));
    endtask

    initial begin
        logic [7:0] exp_free[6];
        logic       seen[256];
        int         distinct;
        int         zeros;
        logic       e;
        logic       l;
        logic [7:0] lv;
        logic       r;

        exp_free = '{8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE1};

        rst        = 1'b1;
        en         = 1'b0;
        load       = 1'b0;
        load_value = '0;
        out_ready  = 1'b0;
        model_reset();

        // Reset state, then free run at full rate.
        async_reset();
        acc_q.delete();
        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 8'h00, 1'b1);
        check("free_count", 32'(acc_q.size()), 32'd6);
        for (int i = 0; i < 6 && i < acc_q.size(); i++)
            check("free_word", 32'(acc_q[i]), 32'(exp_free[i]));

        // Mid-stream async reset, then backpressure on 8'hFC.
        async_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'h00, 1'b1);
        check("bp_start", 32'(lfsr_out), 32'hFC);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 8'h00, 1'b0);
            check("bp_hold", 32'(lfsr_out), 32'hFC);
            check("bp_valid", 32'(out_valid), 32'd1);
        end
        acc_q.delete();
        cycle(1'b1, 1'b0, 8'h00, 1'b1);
        check("bp_acc_count", 32'(acc_q.size()), 32'd1);
        if (acc_q.size() > 0) check("bp_acc_word", 32'(acc_q[0]), 32'hFC);
        check("bp_next", 32'(lfsr_out), 32'hF8);
        // Withdraw: en low with ready low drops valid, no advance.
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        check("withdraw_valid", 32'(out_valid), 32'd0);
        check("withdraw_hold", 32'(lfsr_out), 32'hF8);

        // Full period from reset.
        async_reset();
        cycle(1'b1, 1'b0, 8'h00, 1'b1);
        wrap_cnt = 0;
        acc_q.delete();
        for (int i = 0; i < 255; i++) cycle(1'b1, 1'b0, 8'h00, 1'b1);
        check("period_wrap_count", 32'(wrap_cnt), 32'd1);
        check("period_wrap_now", 32'(wrap), 32'd1);
        check("period_back_to_seed", 32'(lfsr_out), 32'hFF);
        check("period_words", 32'(acc_q.size()), 32'd255);
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        distinct = 0;
        zeros    = 0;
        foreach (acc_q[i]) begin
            if (acc_q[i] == 8'h00) zeros++;
            if (!seen[acc_q[i]]) distinct++;
            seen[acc_q[i]] = 1'b1;
        end
        check("period_distinct", 32'(distinct), 32'd255);
        check("period_nonzero", 32'(zeros), 32'd0);

        // Zero-seed load recovers to SEED with a lockup pulse.
        cycle(1'b1, 1'b1, 8'h00, 1'b1);
        check("zero_lfsr_out", 32'(lfsr_out), 32'hFF);
        check("zero_lockup", 32'(lockup), 32'd1);
        check("zero_valid", 32'(out_valid), 32'd0);
        cycle(1'b1, 1'b0, 8'h00, 1'b1);
        check("zero_lockup_drop", 32'(lockup), 32'd0);
        check("zero_valid_back", 32'(out_valid), 32'd1);
        check("zero_word", 32'(lfsr_out), 32'hFF);

        // Reseed in the same cycle as an accept: load wins, no advance.
        cycle(1'b1, 1'b1, 8'h5A, 1'b1);
        check("reseed_word", 32'(lfsr_out), 32'h5A);
        check("reseed_valid", 32'(out_valid), 32'd0);
        cycle(1'b1, 1'b0, 8'h00, 1'b1);
        check("reseed_first", 32'(lfsr_out), 32'h5A);
        wrap_cnt = 0;
        for (int i = 0; i < 255; i++) cycle(1'b1, 1'b0, 8'h00, 1'b1);
        check("reseed_wrap_count", 32'(wrap_cnt), 32'd1);
        check("reseed_wrap_now", 32'(wrap), 32'd1);
        check("reseed_back", 32'(lfsr_out), 32'h5A);

        // Randomized traffic against the model, with one mid-run reset.
        async_reset();
        for (int i = 0; i < 400; i++) begin
            if (i == 200) async_reset();
            e  = ($urandom % 8) != 0;
            l  = ($urandom % 32) == 0;
            lv = (($urandom % 4) == 0) ? 8'h00 : 8'($urandom);
            r  = ($urandom % 3) != 0;
            cycle(e, l, lv, r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lfsr_gen.md
# lfsr_gen

Parametrised Fibonacci LFSR pseudo-random source with a valid/ready output stream, runtime seed load, all-zero lockup recovery and sequence-wrap detection. It replaces the fixed 8-bit free-running LFSR as the common PRBS generator for test-pattern, scrambler and stimulus blocks. Downstream consumers pull words at their own rate through the handshake.

## Interface
- WIDTH, 8, state and output width; legal range is 3 to 32.
- TAPS, 8'hB8, WIDTH-bit feedback mask; bit i set means state[i] feeds the XOR. Default is the maximal-length polynomial x^8+x^6+x^5+x^4+1.
- SEED, all ones, WIDTH-bit reset and recovery value. Must be non-zero; zero is an elaboration error.
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous active-high reset.
- en  input  1  run enable; while low, no new word is offered.
- load  input  1  load load_value into the state this cycle.
- load_value  input  WIDTH  seed to load.
- out_ready  input  1  consumer accepts lfsr_out this cycle.
- out_valid  output  1  lfsr_out holds a word to be consumed.
- lfsr_out  output  WIDTH  current LFSR state.
- wrap  output  1  one-cycle pulse when the state returns to its start value.
- lockup  output  1  one-cycle pulse when a zero seed was replaced with SEED.

## Operation
- Registers:
  - state (drives lfsr_out)
  - start (sequence start value)
  - out_valid
  - wrap
  - lockup
- Feedback: fb = XOR-reduce(state & TAPS). Next state = {state[WIDTH-2:0], fb}.
- accept = out_valid & out_ready.
- On an accept edge, state advances one step.
- out_valid next value = en, unless a load is happening.
- The first word offered after reset or load is the seed itself, not the advanced value.
- Stability rule: while out_valid=1 and out_ready=0, lfsr_out must not change. The only exceptions are load and rst.
- Deasserting en while out_valid=1 and out_ready=0 withdraws the word at the next edge. No advance occurs.
- Load (has priority over accept):
  - start <= load_value and state <= load_value.
  - If load_value == 0, state and start get SEED instead, and lockup pulses.
  - out_valid <= 0 for one cycle, then follows en.
- Wrap: an accept that makes the next state equal to start sets wrap=1 for one cycle. With a maximal TAPS, this occurs every 2^WIDTH-1 accepts. The non-maximal tap period is whatever the polynomial gives.
- Zero state is unreachable except via load; the check above guarantees the state is never 0.

## Timing
- Reset values, applied asynchronously with no clock needed:
  - lfsr_out = SEED, start = SEED
  - out_valid = 0, wrap = 0, lockup = 0
- Reset release:
  - First edge with en=1 sets out_valid=1 with lfsr_out = SEED.
  - Latency from en rising to out_valid is one cycle.
- Accept at edge N: lfsr_out shows the next value after edge N. out_valid stays high if en=1.
- Full-rate throughput: one word per cycle with en=out_ready=1.
- wrap and lockup are registered. They are high only in the cycle after the causing edge.
- Load and accept in the same cycle: the load wins, the accepted word is consumed, and no advance is applied.
- rst asserted mid-stream: all outputs return immediately to their reset values. Any in-flight word is dropped.

## Test plan
- Async reset: assert rst between clock edges. Response: lfsr_out=8'hFF and out_valid=wrap=lockup=0 immediately, with no clock edge.
- Free run: en=1, out_ready=1 after reset. Response: accepted words 8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE1.
- Backpressure:
  - Stimulus: out_ready=0 for 3 cycles while lfsr_out=8'hFC, out_valid=1; then out_ready=1.
  - Response: lfsr_out holds 8'hFC throughout, then 8'hF8 is the next word.
- Period: continuous accepts from reset. Response: wrap pulses exactly once, in the cycle lfsr_out returns to 8'hFF after 255 accepts. All 255 words are distinct and non-zero.
- Zero seed: load=1, load_value=8'h00. Response: next cycle lfsr_out=8'hFF, lockup=1 for one cycle, and out_valid=0 for one cycle.
- Reseed:
  - Stimulus: load=1, load_value=8'h5A, asserted in the same cycle as an accept.
  - Response: lfsr_out=8'h5A, and no advance is applied. wrap pulses when the state returns to 8'h5A after 255 accepts.
